reg_file_wb: RTL
================

# reg_file_wb

Write-back-side register file for the 5-stage MIPS pipeline: 32 × 32-bit general registers, two asynchronous read ports feeding the ID stage, and one synchronous write port driven by the MEM/WB bundle. It is the far end of the WB control path: the 3-bit WB field carried through the ID/EX and EX/MEM buffers terminates here. The write-back mux (ALU result vs. memory data) is integrated. It supplies `data1`/`data2` into the ID/EX buffer.

## Interface
Parameters:
- `NREG`, 32, number of registers; fixed at 32 for MIPS; address width 5.
- `DW`, 32, data width.

Ports:
- `clk_RF`  in  1  clock; all state changes on rising edge.
- `rstn_RF`  in  1  reset, synchronous, active-low.
- `wb_RF`  in  3  WB control from MEM/WB; [0]=RegWrite, [1]=MemtoReg, [2]=reserved (ignored).
- `wrAddr_RF`  in  5  destination register (rd/rt already selected by RegDst upstream).
- `aluData_RF`  in  32  ALU result from MEM/WB.
- `memData_RF`  in  32  data-memory read data from MEM/WB.
- `rs_RF`  in  5  read address, port 1.
- `rt_RF`  in  5  read address, port 2.
- `data1RF`  out  32  contents of `rs_RF`.
- `data2RF`  out  32  contents of `rt_RF`.
- `wbDataRF`  out  32  selected write-back value (for forwarding).
- `wrCountRF`  out  16  count of committed writes since reset.

## Operation
- Write-back mux: `wbDataRF = wb_RF[1] ? memData_RF : aluData_RF` (combinational).
- Write commit on rising `clk_RF` when `rstn_RF`=1, `wb_RF[0]`=1, and `wrAddr_RF` ≠ 0: `R[wrAddr_RF] <= wbDataRF`; `wrCountRF` increments by 1.
- `wrAddr_RF` = 0 with RegWrite=1: no write, no count; R0 reads 0 permanently.
- Reads are combinational: `data1RF = R[rs_RF]`, `data2RF = R[rt_RF]`; both ports may address the same register.
- `wrCountRF` wraps 0xFFFF → 0x0000 without a flag.
- `wb_RF[2]` has no effect.

## Timing
- Reset: on rising edge with `rstn_RF`=0, all R[0..31] ← 0 and `wrCountRF` ← 0. From the following cycle, `data1RF`/`data2RF` = 0 for any address.
- Reset has priority: a write presented in a reset cycle is discarded and not counted.
- Reset asserted mid-stream clears state at that edge only; writes resume on the first edge with `rstn_RF`=1.
- Write latency: the value is visible on the read ports one edge after commit (same-cycle behaviour governed by Configuration).
- Read latency: zero cycles (combinational) from address or stored-value change.
- No handshake; one write per cycle maximum. Back-to-back writes to the same register: last edge wins.

## Configuration
- `RF_BYPASS_EN` defined: if a committing write (RegWrite=1, addr≠0, `rstn_RF`=1) targets the same address as `rs_RF` or `rt_RF` in the same cycle, that port outputs `wbDataRF` combinationally (write-before-read). This removes the WB→ID hazard.
- Not defined: the read port returns the old stored value until the edge; the hazard must be covered by stalls or forwarding elsewhere.
- Bypass never applies to address 0 or during reset.

## Test plan
- Reset: write R5=0x1234 → assert `rstn_RF`=0 for one edge → `data1RF` at rs=5 reads 0, `wrCountRF`=0.
- Mux/write: wb=3'b001, addr=8, alu=0xDEADBEEF, mem=0x11111111 → after edge R8=0xDEADBEEF; wb=3'b011, addr=9 → R9=0x11111111; `wrCountRF`=2.
- R0 guard: wb=3'b001, addr=0, alu=0xFFFFFFFF → R0 reads 0, `wrCountRF` unchanged.
- Same-cycle read/write: R3=0xA, write 0xB to R3 while rs=rt=3 → with `RF_BYPASS_EN` both ports read 0xB before the edge; without it they read 0xA, then 0xB after the edge.
- Reset priority: `rstn_RF`=0 with wb=3'b001, addr=4, alu=0x55 → R4=0, count=0; next edge with reset released commits 0x55.
- Counter wrap: 65536 valid writes → `wrCountRF`=0x0000.

Source files
------------

// File: rtl/reg_file_wb.sv
// MIPS write-back register file: 32 x DW registers, two combinational read ports,
// one synchronous write port with integrated write-back mux. Optional macro: RF_BYPASS_EN.
module reg_file_wb #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk_RF,
  input  logic          rstn_RF,
  input  logic [2:0]    wb_RF,
  input  logic [4:0]    wrAddr_RF,
  input  logic [DW-1:0] aluData_RF,
  input  logic [DW-1:0] memData_RF,
  input  logic [4:0]    rs_RF,
  input  logic [4:0]    rt_RF,
  output logic [DW-1:0] data1RF,
  output logic [DW-1:0] data2RF,
  output logic [DW-1:0] wbDataRF,
  output logic [15:0]   wrCountRF
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [15:0]   cnt_q, cnt_d;
  logic          commit;
  logic [DW-1:0] rd1, rd2;

  assign wbDataRF  = wb_RF[1] ? memData_RF : aluData_RF;
  assign commit    = rstn_RF && wb_RF[0] && (wrAddr_RF != 5'd0);
  assign wrCountRF = cnt_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (!rstn_RF) begin
      regs_d = '{default: '0};
      cnt_d  = '0;
    end else if (commit) begin
      regs_d[wrAddr_RF] = wbDataRF;
      cnt_d             = cnt_q + 16'd1;
    end
  end

  // NOTE: the whole array is cleared by reset on purpose; software expects all GPRs to read 0.
  always_ff @(posedge clk_RF) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    regs_q <= regs_d;
    cnt_q  <= cnt_d;
  end

  // R0 is hardwired to zero regardless of what the array holds.
  assign rd1 = (rs_RF == 5'd0) ? '0 : regs_q[rs_RF];
  assign rd2 = (rt_RF == 5'd0) ? '0 : regs_q[rt_RF];

`ifdef RF_BYPASS_EN
  assign data1RF = (commit && (rs_RF == wrAddr_RF)) ? wbDataRF : rd1;
  assign data2RF = (commit && (rt_RF == wrAddr_RF)) ? wbDataRF : rd2;
`else
  assign data1RF = rd1;
  assign data2RF = rd2;
`endif

endmodule
